// File: rtl/jtframe_rom_nslots.sv
// jtframe_rom_nslots: read-only SDRAM bank arbiter for SLOTS requesters, each
// backed by a one-entry tagged cache. Selection is fixed priority or round-robin.
module jtframe_rom_nslots #(
    parameter int                 SLOTS   = 4,
    parameter int                 DW      = 16,
    parameter int                 AW      = 20,
    parameter logic [SLOTS*22-1:0] OFFSETS = '0,
    parameter int                 RR      = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SLOTS*AW-1:0] slot_addr,
    input  logic [SLOTS-1:0]    slot_cs,
    input  logic [SLOTS-1:0]    slot_clr,
    output logic [SLOTS-1:0]    slot_ok,
    output logic [SLOTS*DW-1:0] slot_dout,
    output logic [21:0]         sdram_addr,
    output logic                sdram_req,
    input  logic                sdram_ack,
    input  logic                data_dst,
    input  logic                data_rdy,
    input  logic [15:0]         data_read
);

    localparam int TW = (DW == 8)  ? AW - 1 : AW;
    localparam int CW = (DW == 32) ? 32 : 16;
    localparam int IW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t         state;
    logic [TW-1:0]  tag_mem  [SLOTS];
    logic [CW-1:0]  data_mem [SLOTS];
    logic [TW-1:0]  cur_tag  [SLOTS];
    logic [SLOTS-1:0] valid;
    logic [SLOTS-1:0] hit;
    logic [SLOTS-1:0] cand;
    logic [IW-1:0]  ptr;
    logic [IW-1:0]  win;
    logic [IW-1:0]  pick;
    logic           found;
    logic [TW-1:0]  win_tag;
    logic [CW-1:0]  buffer;
    logic [CW-1:0]  fill_data;
    logic           beat;
    logic [21:0]    pick_base;
    logic [21:0]    next_addr;
    int             idx;

    // For byte-wide slots the tag drops the byte bit so both bytes of a word hit
    for (genvar i = 0; i < SLOTS; i++) begin : g_slot
        logic [AW-1:0] addr;
        logic [TW-1:0] tag;
        assign addr = slot_addr[AW*i +: AW];
        if (DW == 8) begin : g_byte
            assign tag = addr[AW-1:1];
            assign slot_dout[DW*i +: DW] = addr[0] ? data_mem[i][15:8] : data_mem[i][7:0];
        end else begin : g_word
            assign tag = addr;
            assign slot_dout[DW*i +: DW] = data_mem[i];
        end
        assign cur_tag[i] = tag;
        assign hit[i]     = slot_cs[i] & valid[i] & (tag_mem[i] == tag);
    end

    assign slot_ok = hit;
    assign cand    = slot_cs & ~hit;

    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int k = 0; k < SLOTS; k++) begin
            idx = k + ((RR != 0) ? int'(ptr) : 0);
            if (idx >= SLOTS) idx = idx - SLOTS;
            if (!found && cand[IW'(idx)]) begin
                found = 1'b1;
                pick  = IW'(idx);
            end
        end
    end

    always_comb begin
        pick_base = (DW == 32) ? 22'({cur_tag[pick], 1'b0}) : 22'(cur_tag[pick]);
        next_addr = pick_base + OFFSETS[22*pick +: 22];
    end

    // A beat arriving together with data_rdy must be part of the fill itself
    always_comb begin
        fill_data = buffer;
        if (data_dst) begin
            if (beat) fill_data[CW-1 -: 16] = data_read;
            else      fill_data[15:0]       = data_read;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sdram_req  <= 1'b0;
            sdram_addr <= '0;
            ptr        <= '0;
            win        <= '0;
            win_tag    <= '0;
            buffer     <= '0;
            beat       <= 1'b0;
            valid      <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                tag_mem[i]  <= '0;
                data_mem[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        win        <= pick;
                        win_tag    <= cur_tag[pick];
                        sdram_addr <= next_addr;
                        sdram_req  <= 1'b1;
                        state      <= REQ;
                    end
                end
                REQ: begin
                    if (sdram_ack) begin
                        sdram_req <= 1'b0;
                        beat      <= 1'b0;
                        buffer    <= '0;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (data_dst) begin
                        buffer <= fill_data;
                        if (DW == 32) beat <= ~beat;
                    end
                    if (data_rdy) begin
                        tag_mem[win]  <= win_tag;
                        data_mem[win] <= fill_data;
                        valid[win]    <= 1'b1;
                        ptr           <= (win == IW'(SLOTS - 1)) ? '0 : win + 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            // Invalidate is applied last so it overrides a coincident fill
            for (int i = 0; i < SLOTS; i++) begin
                if (slot_clr[i]) valid[i] <= 1'b0;
            end
        end
    end

endmodule
